// File: rtl/key_expansion.sv
// key_expansion: iterative AES-128 key schedule; expands one cipher key into 11 round keys and streams them.
module key_expansion #(
  parameter bit OP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);
  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;
  localparam logic [3:0] FIRST = OP ? 4'd0 : 4'd10;
  localparam logic [3:0] LAST = OP ? 4'd10 : 4'd0;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[x];
  endfunction
  state_t state, nxt;
  logic [127:0] mem [0:10];
  logic [3:0] cnt, idx;
  logic [7:0] rcon;
  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic accept;
  assign {w0, w1, w2, w3} = mem[cnt - 4'd1];
  assign t = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign accept = state == IDLE && key_valid;
  assign key_ready = state == IDLE;
  assign rk_valid = state == STREAM;
  assign rk = rk_valid ? mem[idx] : '0;
  assign rk_idx = rk_valid ? idx : '0;
  assign rk_last = rk_valid && idx == LAST;
  always_comb begin
    nxt = state;
    nxt = accept ? EXPAND : (state == EXPAND && cnt == 4'd10) ? STREAM : (rk_valid && rk_ready && rk_last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      rcon <= 8'h01;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt <= 4'd1;
        rcon <= 8'h01;
      end
      if (state == EXPAND) begin
        cnt <= cnt + 4'd1;
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        idx <= FIRST;
      end
      if (rk_valid && rk_ready && !rk_last) idx <= OP ? idx + 4'd1 : idx - 4'd1;
    end
  end
  // buffer holds no reset: contents are rewritten before every read
  always_ff @(posedge clk) begin
    if (accept) mem[0] <= key;
    else if (state == EXPAND) mem[cnt] <= {n0, n1, n2, n3};
  end
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: scoreboard bench driving an encrypt-order and a decrypt-order instance side by side.
module tb_key_expansion;
  logic clk = 0, rst = 1, key_valid = 0, rdy1 = 1, rdy0 = 1;
  logic [127:0] key = '0;
  logic kr1, kr0, v1, v0, last1, last0;
  logic [127:0] rk1, rk0;
  logic [3:0] idx1, idx0;
  int n = 0, nf = 0;
  logic [132:0] q1 [$], q0 [$];
  logic [127:0] seen1 [0:15], seen0 [0:15], ks [0:10];
  logic [7:0] sbt [0:255];
  always #5 clk = ~clk;
  key_expansion #(.OP(1'b1)) u1 (.clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(kr1), .key(key),
    .rk_valid(v1), .rk_ready(rdy1), .rk(rk1), .rk_idx(idx1), .rk_last(last1));
  key_expansion #(.OP(1'b0)) u0 (.clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(kr0), .key(key),
    .rk_valid(v0), .rk_ready(rdy0), .rk(rk0), .rk_idx(idx0), .rk_last(last0));
  task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction
  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbt[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask
  task automatic model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0] rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  task automatic send_key(input logic [127:0] k);
    model(k);
    for (int r = 0; r < 11; r++) q1.push_back({4'(r), r == 10, ks[r]});
    for (int r = 10; r >= 0; r--) q0.push_back({4'(r), r == 0, ks[r]});
    key = k;
    key_valid = 1;
    @(posedge clk) #1;
    key_valid = 0;
  endtask
  task automatic check_latency();
    repeat (9) @(posedge clk) #1;
    chk("lat_low1", v1, 0);
    chk("lat_low0", v0, 0);
    @(posedge clk) #1;
    chk("lat_high1", v1, 1);
    chk("lat_high0", v0, 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 200 && (q1.size() != 0 || q0.size() != 0); i++) @(posedge clk) #1;
    chk("drain", 133'(q1.size() + q0.size()), 0);
    chk("kready1_after", kr1, 1);
    chk("kready0_after", kr0, 1);
  endtask
  task automatic wait_idx1(input logic [3:0] want);
    int i = 0;
    while (!(v1 && idx1 == want) && i < 100) begin
      @(posedge clk) #1;
      i++;
    end
    chk("reach_idx", idx1, want);
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, "_kr1"}, kr1, 1);
    chk({tag, "_kr0"}, kr0, 1);
    chk({tag, "_v1"}, v1, 0);
    chk({tag, "_v0"}, v0, 0);
  endtask
  task automatic pulse_reset();
    rst = 1;
    @(posedge clk) #1;
    rst = 0;
    q1.delete();
    q0.delete();
  endtask
  always @(negedge clk) begin
    logic [132:0] e;
    if (!rst && v1 && rdy1) begin
      chk("q1_nonempty", 133'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("beat1", {idx1, last1, rk1}, e);
        seen1[idx1] = rk1;
      end
    end
    if (!rst && v0 && rdy0) begin
      chk("q0_nonempty", 133'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("beat0", {idx0, last0, rk0}, e);
        seen0[idx0] = rk0;
      end
    end
  end
  initial begin
    build_sbox();
    repeat (2) @(posedge clk) #1;
    rst = 0;
    check_reset_state("reset");
    chk("reset_rk1", {idx1, last1, rk1}, 0);
    chk("reset_rk0", {idx0, last0, rk0}, 0);
    send_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check_latency();
    wait_done();
    chk("fips_e0", seen1[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_e1", seen1[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_e10", seen1[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_d10", seen0[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_d0", seen0[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    send_key(128'h0);
    wait_done();
    chk("zero_e1", seen1[1], 128'h62636363626363636263636362636363);
    chk("zero_e10", seen1[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    send_key({$urandom, $urandom, $urandom, $urandom});
    wait_idx1(4'd3);
    rdy1 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold", {v1, idx1, rk1}, {1'b1, 4'd3, q1[0][127:0]});
      @(posedge clk) #1;
    end
    rdy1 = 1;
    wait_done();
    send_key(128'h000102030405060708090a0b0c0d0e0f);
    repeat (3) @(posedge clk) #1;
    key = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    key_valid = 1;
    chk("kr1_expand", kr1, 0);
    chk("kr0_expand", kr0, 0);
    @(posedge clk) #1;
    key_valid = 0;
    wait_idx1(4'd2);
    key_valid = 1;
    chk("kr1_stream", kr1, 0);
    chk("kr0_stream", kr0, 0);
    @(posedge clk) #1;
    key_valid = 0;
    wait_done();
    send_key(128'h11112222333344445555666677778888);
    repeat (4) @(posedge clk) #1;
    pulse_reset();
    check_reset_state("rst_expand");
    send_key(128'hffeeddccbbaa99887766554433221100);
    wait_idx1(4'd6);
    pulse_reset();
    check_reset_state("rst_stream");
    send_key({$urandom, $urandom, $urandom, $urandom});
    check_latency();
    wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
    $finish;
  end
endmodule
